// File: rtl/snax_csr_pkg.sv
// snax_csr_pkg: address map and launch FSM state shared by the CSR manager
package snax_csr_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_e;

   localparam int RwBase = 0;

   function automatic int ro_base(int rw_count);
      return RwBase + rw_count;
   endfunction

   function automatic int launch_addr(int rw_count, int ro_count);
      return ro_base(rw_count) + ro_count;
   endfunction

endpackage

// File: rtl/snax_csr_manager.sv
// snax_csr_manager: CSR staging/readback with snapshot launch handshake to an accelerator
module snax_csr_manager
   import snax_csr_pkg::*;
#(
   parameter int RegRWCount   = 5,
   parameter int RegROCount   = 2,
   parameter int RegDataWidth = 32,
   parameter int RegAddrWidth = 32
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [RegAddrWidth-1:0]              csr_req_addr_i,
   input  logic [RegDataWidth-1:0]              csr_req_data_i,
   input  logic                                 csr_req_write_i,
   input  logic                                 csr_req_valid_i,
   output logic                                 csr_req_ready_o,
   output logic [RegDataWidth-1:0]              csr_rsp_data_o,
   output logic                                 csr_rsp_valid_o,
   input  logic                                 csr_rsp_ready_i,
   output logic [RegRWCount*RegDataWidth-1:0]   csr_reg_set_o,
   output logic                                 csr_reg_set_valid_o,
   input  logic                                 csr_reg_set_ready_i,
   input  logic [RegROCount*RegDataWidth-1:0]   csr_reg_ro_set_i
);

   localparam logic [RegAddrWidth-1:0] LaunchAddr = RegAddrWidth'(launch_addr(RegRWCount, RegROCount));

   logic [RegDataWidth-1:0] staging [RegRWCount];
   logic [RegDataWidth-1:0] rd_data;
   state_e                  state, state_n;
   logic                    is_launch, accept, launch_acc;

   assign is_launch  = csr_req_write_i && (csr_req_addr_i == LaunchAddr);
   assign csr_req_ready_o = !(csr_rsp_valid_o && !csr_rsp_ready_i) &&
                            !(is_launch && state == PENDING && !csr_reg_set_ready_i);
   assign accept     = csr_req_valid_i && csr_req_ready_o;
   assign launch_acc = accept && is_launch;

   // read data selected from the address presented in the accept cycle
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < RegRWCount; i++)
         if (csr_req_addr_i == RegAddrWidth'(RwBase + i)) rd_data = staging[i];
      for (int i = 0; i < RegROCount; i++)
         if (csr_req_addr_i == RegAddrWidth'(ro_base(RegRWCount) + i))
            rd_data = csr_reg_ro_set_i[i*RegDataWidth +: RegDataWidth];
      if (csr_req_addr_i == LaunchAddr) rd_data = RegDataWidth'(state == PENDING);
   end

   // staging registers take accepted writes to RW space only
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < RegRWCount; i++) staging[i] <= '0;
      end else begin
         for (int i = 0; i < RegRWCount; i++)
            if (accept && csr_req_write_i && csr_req_addr_i == RegAddrWidth'(RwBase + i))
               staging[i] <= csr_req_data_i;
      end
   end

   // one-cycle read response, held until the requester takes it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         csr_rsp_valid_o <= 1'b0;
         csr_rsp_data_o  <= '0;
      end else if (accept && !csr_req_write_i) begin
         csr_rsp_valid_o <= 1'b1;
         csr_rsp_data_o  <= rd_data;
      end else if (csr_rsp_ready_i) begin
         csr_rsp_valid_o <= 1'b0;
      end
   end

   // launched config is a snapshot of staging, frozen until the next launch
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         csr_reg_set_o <= '0;
      end else if (launch_acc) begin
         for (int i = 0; i < RegRWCount; i++)
            csr_reg_set_o[i*RegDataWidth +: RegDataWidth] <= staging[i];
      end
   end

   // launch FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_n;
   end

   // a launch always (re)enters PENDING; otherwise leave on accelerator ready
   always_comb begin
      state_n = launch_acc ? PENDING :
                (state == PENDING && !csr_reg_set_ready_i) ? PENDING : IDLE;
   end

   // launch valid is exactly the PENDING state
   always_comb begin
      csr_reg_set_valid_o = (state == PENDING);
   end

endmodule

// File: tb/tb_snax_csr_manager.sv
// tb_snax_csr_manager: directed stimulus with a response scoreboard for snax_csr_manager
module tb_snax_csr_manager;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   localparam logic [159:0] SNAP1 = {32'h7, 32'h5, 32'h30, 32'h20, 32'h10};
   localparam logic [159:0] SNAP2 = {32'h7, 32'h5, 32'h30, 32'h20, 32'hAA};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  req_addr = '0, req_data = '0;
   logic         req_write = 1'b0, req_valid = 1'b0, req_ready;
   logic [31:0]  rsp_data;
   logic         rsp_valid, rsp_ready = 1'b1;
   logic [159:0] set_o;
   logic         set_valid, set_ready = 1'b0;
   logic [63:0]  ro_set = {32'hBEEF, 32'h1};

   int   total = 0, bad = 0, cyc = 0;
   bit   seen = 0;
   exp_t q[$];

   snax_csr_manager dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .csr_req_addr_i      (req_addr),
      .csr_req_data_i      (req_data),
      .csr_req_write_i     (req_write),
      .csr_req_valid_i     (req_valid),
      .csr_req_ready_o     (req_ready),
      .csr_rsp_data_o      (rsp_data),
      .csr_rsp_valid_o     (rsp_valid),
      .csr_rsp_ready_i     (rsp_ready),
      .csr_reg_set_o       (set_o),
      .csr_reg_set_valid_o (set_valid),
      .csr_reg_set_ready_i (set_ready),
      .csr_reg_ro_set_i    (ro_set)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // enter at posedge+1; returns at posedge+1 after acceptance
   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [31:0] e);
      int  n = 0;
      bit  ok = 0;
      req_addr = a; req_data = d; req_write = w; req_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk);
         n++;
      end while (!ok && n < 50);
      #1;
      req_valid = 1'b0;
      if (!ok) begin
         total++; bad++;
         $display("FAIL req_timeout: addr %0h not accepted in 50 cycles", a);
      end else if (!w) q.push_back('{e, cyc});
   endtask

   // response monitor: latency on first appearance, data on handshake
   initial forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got %0h expected none", rsp_data);
         end else begin
            if (!seen) begin
               chk("rsp_latency", 160'(cyc), 160'(q[0].c));
               seen = 1;
            end
            if (rsp_ready) begin
               chk("rsp_data", 160'(rsp_data), 160'(q[0].d));
               void'(q.pop_front());
               seen = 0;
            end
         end
      end else seen = 0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", 160'(rsp_valid), 160'(0));
      chk("rst_rsp_data", 160'(rsp_data), 160'(0));
      chk("rst_set_valid", 160'(set_valid), 160'(0));
      chk("rst_set_o", set_o, 160'(0));
      chk("rst_req_ready", 160'(req_ready), 160'(1));
      rst_n = 1'b1;
      @(posedge clk); #1;
      req(0, 32'h10, 1, 0);
      req(1, 32'h20, 1, 0);
      req(2, 32'h30, 1, 0);
      req(3, 32'h5, 1, 0);
      req(4, 32'h7, 1, 0);
      req(2, 0, 0, 32'h30);
      req(0, 0, 0, 32'h10);
      req(4, 0, 0, 32'h7);
      req(5, 0, 0, 32'h1);
      req(6, 0, 0, 32'hBEEF);
      req(5, 32'h99, 1, 0);
      req(5, 0, 0, 32'h1);
      req(7, 0, 0, 32'h0);
      req(100, 0, 0, 32'h0);
      // launch and hold off the accelerator
      req(7, 32'hDEAD, 1, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("pend_valid", 160'(set_valid), 160'(1));
         chk("pend_snap", set_o, SNAP1);
         @(posedge clk); #1;
      end
      req(0, 32'hAA, 1, 0);
      @(negedge clk);
      chk("pend_snap_kept", set_o, SNAP1);
      @(posedge clk); #1;
      req(7, 0, 0, 32'h1);
      // second launch stalls until accelerator is ready
      req_addr = 7; req_write = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      chk("relaunch_stall", 160'(req_ready), 160'(0));
      @(posedge clk); #1;
      set_ready = 1'b1;
      @(negedge clk);
      chk("relaunch_ready", 160'(req_ready), 160'(1));
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("relaunch_valid", 160'(set_valid), 160'(1));
      chk("relaunch_snap", set_o, SNAP2);
      @(posedge clk); #1;
      set_ready = 1'b0;
      @(negedge clk);
      chk("launch_done", 160'(set_valid), 160'(0));
      @(posedge clk); #1;
      // response back-pressure
      rsp_ready = 1'b0;
      req(2, 0, 0, 32'h30);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("bp_req_ready", 160'(req_ready), 160'(0));
         chk("bp_rsp_stable", 160'(rsp_data), 160'(32'h30));
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      req(100, 0, 0, 32'h0);
      // reset while launch pending and response outstanding
      req(7, 0, 1, 0);
      rsp_ready = 1'b0;
      req(0, 0, 0, 32'hAA);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_set_valid", 160'(set_valid), 160'(0));
      chk("arst_rsp_valid", 160'(rsp_valid), 160'(0));
      chk("arst_rsp_data", 160'(rsp_data), 160'(0));
      chk("arst_set_o", set_o, 160'(0));
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      set_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_rsp_valid", 160'(rsp_valid), 160'(0));
         chk("post_rst_set_valid", 160'(set_valid), 160'(0));
      end
      @(posedge clk); #1;
      req(0, 0, 0, 32'h0);
      repeat (3) @(posedge clk);
      chk("queue_drained", 160'(q.size()), 160'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
